// File: rtl/shift_rx.sv
// Serial-in receiver: assembles MSB-first frames after a Load strobe.
// Emits a Valid pulse per completed word and an Err pulse per aborted frame.
module shift_rx #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Load,
  input  logic             Din,
  output logic [WIDTH-1:0] Dout,
  output logic             Valid,
  output logic             Busy,
  output logic             Err
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           r_state;
  state_t           w_state_nx;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nx;
  logic [WIDTH-1:0] r_sreg;
  logic [WIDTH-1:0] w_sreg_nx;
  logic [WIDTH-1:0] w_shifted;
  logic [WIDTH-1:0] r_dout;
  logic [WIDTH-1:0] w_dout_nx;
  logic             r_valid;
  logic             w_valid_nx;
  logic             r_err;
  logic             w_err_nx;
  logic             r_busy;

  assign w_shifted = {r_sreg[WIDTH-2:0], Din};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_sreg  <= '0;
      r_dout  <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_sreg  <= w_sreg_nx;
      r_dout  <= w_dout_nx;
      r_valid <= w_valid_nx;
      r_err   <= w_err_nx;
      r_busy  <= (w_state_nx == SHIFT);
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_sreg_nx  = r_sreg;
    w_dout_nx  = r_dout;
    w_valid_nx = 1'b0;
    w_err_nx   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (Load) begin
          w_state_nx = SHIFT;
          w_cnt_nx   = '0;
        end
      end
      SHIFT: begin
        // Load on the final bit completes this word and chains the next
        if (r_cnt == LAST) begin
          w_sreg_nx  = w_shifted;
          w_dout_nx  = w_shifted;
          w_valid_nx = 1'b1;
          w_cnt_nx   = '0;
          w_state_nx = Load ? SHIFT : IDLE;
        end else if (Load) begin
          w_err_nx = 1'b1;
          w_cnt_nx = '0;
        end else begin
          w_sreg_nx = w_shifted;
          w_cnt_nx  = r_cnt + CW'(1);
        end
      end
    endcase
  end

  assign Dout  = r_dout;
  assign Valid = r_valid;
  assign Busy  = r_busy;
  assign Err   = r_err;

endmodule

// File: tb/tb_shift_rx.sv
// Bench for shift_rx: directed frames, expected words/errors queued,
// a negedge monitor pops and compares whenever Valid or Err appears.
module tb_shift_rx;

  logic       clk;
  logic       rst;
  logic       Load;
  logic       Din;
  logic [3:0] Dout;
  logic       Valid;
  logic       Busy;
  logic       Err;

  typedef struct packed {
    logic       err;
    logic [3:0] data;
  } exp_t;

  exp_t q[$];
  int   checks;
  int   failures;

  shift_rx #(.WIDTH(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .Load (Load),
    .Din  (Din),
    .Dout (Dout),
    .Valid(Valid),
    .Busy (Busy),
    .Err  (Err)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic drive(input logic ld, input logic d);
    Load = ld;
    Din  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic e, input logic [3:0] d);
    exp_t x;
    x.err  = e;
    x.data = d;
    q.push_back(x);
  endtask

  // monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (Valid && Err) chk("valid_err_overlap", 1, 0);
      if (Valid || Err) begin
        if (q.size() == 0) begin
          chk("unexpected_pulse", {30'd0, Err, Valid}, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("pulse_kind_err", int'(Err), int'(e.err));
          if (!e.err) chk("word", int'(Dout), int'(e.data));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst  = 1'b1;
    Load = 1'b0;
    Din  = 1'b0;
    #1;
    chk("rst_dout", int'(Dout), 0);
    chk("rst_flags", int'({Valid, Busy, Err}), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(0, 0);

    // basic frame 0100
    push(0, 4'd4);
    drive(1, 1);
    chk("basic_busy_k", int'(Busy), 1);
    drive(0, 0);
    drive(0, 1);
    drive(0, 0);
    chk("basic_valid_early", int'(Valid), 0);
    drive(0, 0);
    chk("basic_valid", int'(Valid), 1);
    chk("basic_busy_done", int'(Busy), 0);
    drive(0, 0);
    chk("basic_valid_1cyc", int'(Valid), 0);

    // back-to-back 1011 then 0110
    push(0, 4'd11);
    push(0, 4'd6);
    drive(1, 0);
    drive(0, 1);
    drive(0, 0);
    drive(0, 1);
    drive(1, 1);
    chk("b2b_first", int'(Dout), 11);
    chk("b2b_busy", int'(Busy), 1);
    drive(0, 0);
    drive(0, 1);
    drive(0, 1);
    chk("b2b_busy_mid", int'(Busy), 1);
    drive(0, 0);
    chk("b2b_second", int'(Dout), 6);
    drive(0, 0);

    // abort then 0011
    drive(1, 0);
    drive(0, 1);
    drive(0, 1);
    push(1, 4'd0);
    drive(1, 0);
    chk("abort_err", int'(Err), 1);
    chk("abort_dout_hold", int'(Dout), 6);
    push(0, 4'd3);
    drive(0, 0);
    chk("abort_err_1cyc", int'(Err), 0);
    drive(0, 0);
    drive(0, 1);
    chk("abort_dout_hold2", int'(Dout), 6);
    drive(0, 1);
    chk("abort_word", int'(Dout), 3);
    drive(0, 0);

    // reset mid-frame
    push(0, 4'hA);
    drive(1, 0);
    drive(0, 1);
    drive(0, 0);
    drive(0, 1);
    drive(0, 0);
    chk("rst_pre_word", int'(Dout), 10);
    drive(1, 0);
    drive(0, 1);
    drive(0, 1);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_dout", int'(Dout), 0);
    chk("async_rst_flags", int'({Valid, Busy, Err}), 0);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    drive(0, 1);
    chk("post_rst_busy", int'(Busy), 0);
    push(0, 4'd15);
    drive(1, 0);
    drive(0, 1);
    drive(0, 1);
    drive(0, 1);
    drive(0, 1);
    chk("post_rst_word", int'(Dout), 15);

    // idle noise
    for (int i = 0; i < 10; i++) begin
      drive(0, 1'(i));
      chk("idle_busy", int'(Busy), 0);
    end
    chk("idle_dout", int'(Dout), 15);

    drive(0, 0);
    drive(0, 0);
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
